// File: rtl/vga_timing_pkg.sv
// 640x480@60Hz VGA timing constants and the shared coordinate type.
package vga_timing_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800
  localparam int H_SYNC_START = H_ACTIVE + H_FP;                   // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;             // 752 (exclusive)

  localparam int V_ACTIVE     = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525
  localparam int V_SYNC_START = V_ACTIVE + V_FP;                   // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;             // 492 (exclusive)

  // Sync active level: 0 = active-low, as on a standard VGA connector.
  localparam bit SYNC_POL     = 1'b0;

  localparam int COORD_W      = 10;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter, a wrap strobe, and the sync decode.
// The horizontal axis counts every cycle. The vertical axis counts on the horizontal wrap.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  output coord_t cnt_o,
  output logic   wrap_o,
  output logic   sync_o
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);
  localparam coord_t SS   = coord_t'(SYNC_START);
  localparam coord_t SE   = coord_t'(SYNC_END);

  coord_t cnt_q, cnt_d;
  logic   at_last;

  // Using >= rather than == means an out-of-range value still wraps at the next
  // wrap event, so the counter cannot lock up.
  assign at_last = (cnt_q >= LAST);
  assign wrap_o  = en_i & at_last;

  // Next count: hold when disabled, wrap to zero at the end of the axis, otherwise add one.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = at_last ? '0 : cnt_q + coord_t'(1);
  end

  // Counter register. Reset has priority over counting.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Sync is decoded from the registered count, so it lines up with cnt_o with no latency.
  always_comb begin
    sync_o = ~SYNC_POL;
    if (cnt_q >= SS && cnt_q < SE) sync_o = SYNC_POL;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_controller.sv
// VGA timing generator. Free-running x/y pixel counters with hsync/vsync decode.
// Optional feature macro VGA_VIDEO_ON_EN adds the video_on output, which is 1
// inside the visible area (x<H_ACTIVE && y<V_ACTIVE).
module vga_controller
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic   vgaclk,
  input  logic   reset,
  output logic   hsync,
  output logic   vsync,
`ifdef VGA_VIDEO_ON_EN
  output logic   video_on,
`endif
  output coord_t x,
  output coord_t y
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_wrap;

  vga_axis_counter #(
    .TOTAL(HT), .SYNC_START(H_ACTIVE + H_FP),
    .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .SYNC_POL(SYNC_POL)
  ) u_h (
    .clk_i(vgaclk), .rst_i(reset), .en_i(1'b1),
    .cnt_o(x), .wrap_o(h_wrap), .sync_o(hsync)
  );

  // The vertical axis steps only on the cycle the line wraps. Its own wrap strobe
  // marks the frame boundary, which is not needed here.
  vga_axis_counter #(
    .TOTAL(VT), .SYNC_START(V_ACTIVE + V_FP),
    .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .SYNC_POL(SYNC_POL)
  ) u_v (
    .clk_i(vgaclk), .rst_i(reset), .en_i(h_wrap),
    .cnt_o(y), .wrap_o(), .sync_o(vsync)
  );

`ifdef VGA_VIDEO_ON_EN
  // Visible-area decode. It follows x/y directly, so it is 1 in reset at (0,0).
  assign video_on = (x < coord_t'(H_ACTIVE)) && (y < coord_t'(V_ACTIVE));
`endif

endmodule

// File: tb/tb_vga_controller.sv
// Scoreboard bench for vga_controller. Instance A uses the standard 640x480 timing.
// Instance B keeps the standard 800-pixel line but has a 12-line frame:
// 6 active lines, vsync on lines 8..9, and a 9600-cycle frame. This lets the
// vertical sync window and the frame wrap be exercised in a short run.
// Expected records {cycle, instance, x, y, hsync, vsync, video_on} are queued.
// The monitor compares them at the falling edge of the cycle they name.
module tb_vga_controller;
  import vga_timing_pkg::*;

  logic   vgaclk = 1'b0;
  logic   rst_a, rst_b;
  logic   hs_a, vs_a, hs_b, vs_b;
  coord_t x_a, y_a, x_b, y_b;
`ifdef VGA_VIDEO_ON_EN
  logic   von_a, von_b;
`endif

  always #5 vgaclk = ~vgaclk;

  vga_controller u_dut_a (
    .vgaclk(vgaclk), .reset(rst_a), .hsync(hs_a), .vsync(vs_a),
`ifdef VGA_VIDEO_ON_EN
    .video_on(von_a),
`endif
    .x(x_a), .y(y_a)
  );

  vga_controller #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_dut_b (
    .vgaclk(vgaclk), .reset(rst_b), .hsync(hs_b), .vsync(vs_b),
`ifdef VGA_VIDEO_ON_EN
    .video_on(von_b),
`endif
    .x(x_b), .y(y_b)
  );

  typedef struct {
    int n; int id; int x; int y; int hs; int vs; int von;   // -1 = don't care
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  localparam int LAST_CYC = 9700;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  function automatic void push(int n, int id, int x, int y, int hs, int vs, int von);
    exp_t e;
    e.n = n; e.id = id; e.x = x; e.y = y; e.hs = hs; e.vs = vs; e.von = von;
    sbq.push_back(e);
  endfunction

  // Stimulus: reset both instances for two cycles, then release them. Instance A
  // takes a one-cycle reset at (300,2) as a mid-frame reset. Cycle c is the falling
  // edge after c rising edges past reset release.
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    // Instance A: reset state, hsync edges, line wrap.
    push(0,    0, 0,   0, 1, 1, 1);
    push(655,  0, 655, 0, 1, 1, 0);
    push(656,  0, 656, 0, 0, 1, 0);
    push(751,  0, 751, 0, 0, 1, 0);
    push(752,  0, 752, 0, 1, 1, 0);
    push(799,  0, 799, 0, 1, 1, 0);
    push(800,  0, 0,   1, 1, 1, 1);
    push(1456, 0, 656, 1, 0, 1, 0);
    push(1900, 0, 300, 2, 1, 1, 1);
    // Instance B: visible edges, vsync window, frame wrap.
    push(0,    1, 0,   0,  1, 1, 1);
    push(640,  1, 640, 0,  1, 1, 0);
    push(656,  1, 656, 0,  0, 1, 0);
    push(4639, 1, 639, 5,  1, 1, 1);
    push(4800, 1, 0,   6,  1, 1, 0);
    push(6399, 1, 799, 7,  1, 1, 0);
    push(6400, 1, 0,   8,  1, 0, 0);
    push(7999, 1, 799, 9,  1, 0, 0);
    push(8000, 1, 0,   10, 1, 1, 0);
    push(9599, 1, 799, 11, 1, 1, 0);
    push(9600, 1, 0,   0,  1, 1, 1);
    push(9601, 1, 1,   0,  1, 1, 1);
    repeat (2) @(posedge vgaclk);
    @(negedge vgaclk);                 // cycle 0
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (1900) @(negedge vgaclk);   // cycle 1900, A at (300,2)
    rst_a = 1'b1;
    push(1901, 0, 0,   0, 1, 1, 1);
    push(1902, 0, 1,   0, 1, 1, 1);
    push(2557, 0, 656, 0, 0, 1, 0);
    push(2700, 0, 799, 0, 1, 1, 0);
    push(2701, 0, 0,   1, 1, 1, 1);
    @(negedge vgaclk);                 // cycle 1901
    rst_a = 1'b0;
  end

  // Monitor: match queued records against the sampled outputs. Also apply
  // per-cycle invariants and count sync activity on instance B.
  initial begin
    int vs_low_b, hs_low_b, period_b;
    vs_low_b = 0; hs_low_b = 0; period_b = -1;
    repeat (2) @(posedge vgaclk);
    for (int c = 0; c <= LAST_CYC; c++) begin
      @(negedge vgaclk);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].n == c) begin
          exp_t e;
          string tag;
          e = sbq[i];
          tag = $sformatf("%s@%0d", (e.id == 0) ? "A" : "B", c);
          if (e.id == 0) begin
            chk({tag, " x"}, int'(x_a), e.x);
            chk({tag, " y"}, int'(y_a), e.y);
            chk({tag, " hsync"}, int'(hs_a), e.hs);
            chk({tag, " vsync"}, int'(vs_a), e.vs);
`ifdef VGA_VIDEO_ON_EN
            chk({tag, " video_on"}, int'(von_a), e.von);
`endif
          end else begin
            chk({tag, " x"}, int'(x_b), e.x);
            chk({tag, " y"}, int'(y_b), e.y);
            chk({tag, " hsync"}, int'(hs_b), e.hs);
            chk({tag, " vsync"}, int'(vs_b), e.vs);
`ifdef VGA_VIDEO_ON_EN
            chk({tag, " video_on"}, int'(von_b), e.von);
`endif
          end
          sbq.delete(i);
        end
      end
      // Invariants on both instances.
      chk("A x range", int'(x_a < 10'd800), 1);
      chk("A y range", int'(y_a < 10'd525), 1);
      chk("A hsync in visible", int'(!hs_a && x_a < 10'd640), 0);
      chk("B x range", int'(x_b < 10'd800), 1);
      chk("B y range", int'(y_b < 10'd12), 1);
      chk("B hsync in visible", int'(!hs_b && x_b < 10'd640), 0);
      // Sync widths and the frame period on instance B.
      if (c < 9600 && !vs_b) vs_low_b++;
      if (c < 800 && !hs_b) hs_low_b++;
      if (c > 0 && period_b < 0 && x_b == 10'd0 && y_b == 10'd0) period_b = c;
      if (c == 9600) begin
        chk("B vsync low cycles per frame", vs_low_b, 1600);
        chk("B hsync low cycles per line", hs_low_b, 96);
        chk("B frame period", period_b, 9600);
      end
    end
    while (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL unmatched record for cycle %0d: got none expected a sample", sbq[0].n);
      void'(sbq.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
